sum3_serial_unadder: RTL and testbench
======================================

# sum3_serial_unadder

Bit-serial inverse of the three-operand modular adder: given a sum word and two known addends, recovers the missing third addend, `diff = (sum - a - b) mod 2^W`. It also reports the exact integer borrow, so `sum - a - b = diff - borrow * 2^W`. It sits at the consumer side of the 3-input adder datapath as a low-area residue/recovery checker. It uses a valid/ready handshake on both sides and processes one bit per clock.

## Interface
- `W`, default 4: operand width in bits; legal range 2..16.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: block can accept a request.
- `sum` input W: sum word.
- `a` input W: first known addend.
- `b` input W: second known addend.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `diff` output W: recovered addend, `(sum - a - b) mod 2^W`.
- `borrow` output 2: integer borrow, 0..2; `sum - a - b = diff - borrow*2^W`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, capture `sum`, `a`, `b` into shift registers.
  - Clear the 2-bit borrow register and the bit counter; go to SHIFT.
- SHIFT: one bit per cycle, LSB first.
  - `t = a_i + b_i + br - s_i`, where t ranges -1..4.
  - Result bit = `t & 1`; shift it into the diff register from the MSB end.
  - `br_next`:
    - t = -1 or 0 -> 0
    - t = 1 or 2 -> 1
    - t = 3 or 4 -> 2
  - The borrow register never exceeds 2.
  - After W bit-steps, go to DONE.
- DONE:
  - `out_valid`=1; `diff` and `borrow` are held stable until `out_valid && out_ready`.
  - On that handshake, go to IDLE.
- `in_ready` is 0 in SHIFT and DONE. Requests presented then are ignored, not queued. A producer must hold `in_valid`.
- `diff` and `borrow` are registered. They keep the last result after the DONE handshake until the next capture overwrites them.
- Input ports are sampled only at the capture edge. Later changes on `sum`, `a`, `b` do not affect the operation in flight.

## Timing
- Reset (async assert, takes effect immediately):
  - state = IDLE.
  - `in_ready`=1, `out_valid`=0, `diff`=0, `borrow`=0.
  - Internal shift registers, borrow register and counter cleared.
- Reset mid-SHIFT or mid-DONE aborts the operation; no partial result is ever flagged valid.
- Deassertion is synchronized externally; the first capture can occur on the first rising edge with `rst`=0.
- Latency:
  - Capture edge ends cycle T.
  - SHIFT occupies cycles T+1..T+W.
  - `out_valid` rises in cycle T+W+1.
- Drain:
  - If `out_ready`=1 in cycle T+W+1, `out_valid` falls and `in_ready` rises in cycle T+W+2.
  - Maximum throughput is one result per W+2 cycles.
- Backpressure: `out_valid` stays high indefinitely while `out_ready`=0.
- `out_ready` asserted while `out_valid`=0 has no effect.
- IDLE with `in_valid`=0: no state change, outputs hold.
- Boundaries:
  - All-ones operands: sum=0, a=b=2^W-1 gives borrow=2, diff=2.
  - Exact match: sum = a+b gives diff=0, borrow=0.
  - No wrap: sum ≥ a+b gives borrow=0.

## Test plan
- Reset behaviour:
  - Stimulus: assert `rst` asynchronously mid-SHIFT.
  - Response: `out_valid`=0, `in_ready`=1, `diff`=0, `borrow`=0 immediately.
  - Response: no `out_valid` pulse follows for the aborted request.
- Basic recovery and latency (W=4):
  - Stimulus: sum=5, a=3, b=1.
  - Response: diff=1, borrow=0.
  - Response: `out_valid` first high exactly 5 cycles after the capture cycle.
- Wrap with maximum borrow:
  - Stimulus: sum=2, a=15, b=15.
  - Response: diff=4, borrow=2, since 2-30 = 4-32.
- Single borrow:
  - Stimulus: sum=0, a=1, b=0.
  - Response: diff=15, borrow=1.
- Backpressure and ignored input:
  - Stimulus: hold `out_ready`=0 for 10 cycles in DONE while driving new `in_valid` with other operands.
  - Response: `diff`/`borrow` stable, `in_ready`=0, the new request is not captured.
  - Response: after `out_ready`=1, IDLE follows and the held request is captured on the next edge.
- Exhaustive sweep at W=4:
  - Stimulus: all 4096 (sum,a,b) triples, back-to-back with `out_ready`=1.
  - Response: every result satisfies `diff - 16*borrow == sum - a - b`.
  - Response: spacing is exactly 6 cycles per result.

Source files
------------

// File: rtl/sum3_serial_unadder.sv
// Bit-serial inverse of a three-operand modular adder: recovers diff = (sum - a - b) mod 2^W
// and the integer borrow (0..2), one bit per clock, valid/ready on both sides.
module sum3_serial_unadder #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] sum,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic [1:0]   borrow
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         r_state;
  logic [W-1:0]   r_sum;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_diff;
  logic [1:0]     r_br;
  logic [CW-1:0]  r_cnt;
  logic           r_in_ready;
  logic           r_out_valid;

  logic [2:0]     w_u;
  logic           w_bit;
  logic [1:0]     w_br_next;

  // w_u = t + 1, so the digit term t = a_i + b_i + br - s_i (-1..4) becomes unsigned 0..5:
  // the result bit is the parity of t and the next borrow is floor((t+1)/2).
  assign w_u       = 3'(r_a[0]) + 3'(r_b[0]) + 3'(r_br) + 3'd1 - 3'(r_sum[0]);
  assign w_bit     = ~w_u[0];
  assign w_br_next = w_u[2:1];

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign borrow    = r_br;

  // NOTE: all state updates use non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sum       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_br        <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sum      <= sum;
            r_a        <= a;
            r_b        <= b;
            r_br       <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_sum  <= r_sum >> 1;
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_diff <= {w_bit, r_diff[W-1:1]};
          r_br   <= w_br_next;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(W - 1)) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum3_serial_unadder.sv
// Self-checking bench for sum3_serial_unadder (W=4): directed boundaries, reset abort,
// backpressure, random operations and an exhaustive back-to-back sweep.
module tb_sum3_serial_unadder;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic [1:0]   borrow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sum3_serial_unadder #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
  );

  // Reference model: plain integer arithmetic on the defining identity.
  function automatic int model_diff(input int s, input int x, input int y);
    int d;
    d = s - x - y;
    return ((d % M) + M) % M;
  endfunction

  function automatic int model_borrow(input int s, input int x, input int y);
    return (model_diff(s, x, y) - (s - x - y)) / M;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns edges waited until out_valid (or the budget).
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_valid_timeout", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_out_valid", {31'b0, out_valid}, 32'd0);
    check("drain_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  // Full operation starting in IDLE at posedge+1; inputs are scrambled after capture.
  task automatic do_op(input int s, input int x, input int y, input int hold, input bit chk_lat);
    int n;
    sum = W'(s); a = W'(x); b = W'(y); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sum = W'($urandom); a = W'($urandom); b = W'($urandom);
    check("capture_in_ready", {31'b0, in_ready}, 32'd0);
    wait_valid(n);
    if (chk_lat) check("latency_edges", n, W);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    check("op_diff", {28'b0, diff}, model_diff(s, x, y));
    check("op_borrow", {30'b0, borrow}, model_borrow(s, x, y));
    drain();
  endtask

  initial begin
    int n;
    int pulses;
    int idx;
    int got;
    int last;
    int cyc;
    int qs[$];
    int qa[$];
    int qb[$];
    int es, ea, eb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sum = '0; a = '0; b = '0;
    #2;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_diff", {28'b0, diff}, 32'd0);
    check("reset_borrow", {30'b0, borrow}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed boundaries
    do_op(5, 3, 1, 0, 1'b1);
    do_op(2, 15, 15, 2, 1'b1);
    do_op(0, 1, 0, 0, 1'b0);
    do_op(0, 15, 15, 1, 1'b0);
    do_op(9, 4, 5, 0, 1'b0);
    do_op(15, 3, 7, 0, 1'b0);

    // Async reset mid-SHIFT
    sum = 4'd7; a = 4'd2; b = 4'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_diff", {28'b0, diff}, 32'd0);
    check("abort_borrow", {30'b0, borrow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    check("abort_idle", {31'b0, in_ready}, 32'd1);

    // Backpressure with a competing request held on the inputs
    sum = 4'd6; a = 4'd1; b = 4'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(n);
    sum = 4'd11; a = 4'd4; b = 4'd9; in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_diff", {28'b0, diff}, model_diff(6, 1, 2));
      check("bp_borrow", {30'b0, borrow}, model_borrow(6, 1, 2));
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    end
    drain();
    check("bp_held_diff", {28'b0, diff}, model_diff(6, 1, 2));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_captured", {31'b0, in_ready}, 32'd0);
    wait_valid(n);
    check("bp_latency", n, W);
    check("bp_new_diff", {28'b0, diff}, model_diff(11, 4, 9));
    check("bp_new_borrow", {30'b0, borrow}, model_borrow(11, 4, 9));
    drain();

    // Random operations with random backpressure
    for (int i = 0; i < 24; i++) begin
      do_op(int'($urandom_range(M - 1)), int'($urandom_range(M - 1)),
            int'($urandom_range(M - 1)), int'($urandom_range(3)), 1'b1);
    end

    // Exhaustive back-to-back sweep
    out_ready = 1'b1;
    idx = 0; got = 0; last = -1; cyc = 0;
    while (got < M * M * M && cyc < 30000) begin
      if (out_valid) begin
        es = qs.pop_front(); ea = qa.pop_front(); eb = qb.pop_front();
        check("sweep_diff", {28'b0, diff}, model_diff(es, ea, eb));
        check("sweep_borrow", {30'b0, borrow}, model_borrow(es, ea, eb));
        if (last >= 0) check("sweep_spacing", cyc - last, W + 2);
        last = cyc;
        got++;
      end
      if (in_ready && idx < M * M * M) begin
        es = (idx >> (2 * W)) % M; ea = (idx >> W) % M; eb = idx % M;
        sum = W'(es); a = W'(ea); b = W'(eb); in_valid = 1'b1;
        qs.push_back(es); qa.push_back(ea); qb.push_back(eb);
        idx++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("sweep_count", got, M * M * M);
    out_ready = 1'b0;
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
